// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root block.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold values up to n/2 + 1.
  function automatic int cycle_w(input int n);
    return $clog2(n / 2 + 2);
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One digit-by-digit square-root iteration: consumes one operand bit-pair.
module isqrt_step #(
  parameter int RW = 4
) (
  input  logic [RW+1:0] rem_i,
  input  logic [RW-1:0] root_i,
  input  logic [1:0]    pair_i,
  output logic [RW+1:0] rem_o,
  output logic [RW-1:0] root_o
);

  logic [RW+1:0] rem_sh;
  logic [RW+1:0] trial;
  logic          take;

  // The discarded top bits of rem<<2 and root<<1 are always zero mid-iteration.
  always_comb begin
    rem_sh = (rem_i << 2) | {{RW{1'b0}}, pair_i};
    trial  = {root_i, 2'b01};
    take   = (rem_sh >= trial);
    rem_o  = take ? (rem_sh - trial) : rem_sh;
    root_o = (root_i << 1) | {{(RW-1){1'b0}}, take};
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt) unit: one result bit per clock, IDLE -> ITER -> DONE.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int N          = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N-1:0]                 data_in,
  output logic                         busy,
  output logic                         done,
  output logic [N/2-1:0]               data_out,
  output logic [N/2:0]                 remainder,
  output logic [$clog2(N/2+2)-1:0]     cycles
);

  localparam int RW  = N / 2;
  localparam int CW  = cycle_w(N);
  localparam int RW1 = RW + 1;

  state_t          state_q, state_d;
  logic [N-1:0]    opnd_q, opnd_d;
  logic [RW-1:0]   root_q, root_d, root_nx;
  logic [RW+1:0]   rem_q, rem_d, rem_nx;
  logic [CW-1:0]   cycles_q, cycles_d;

  isqrt_step #(.RW(RW)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .pair_i (opnd_q[N-1:N-2]),
    .rem_o  (rem_nx),
    .root_o (root_nx)
  );

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    root_d   = root_q;
    rem_d    = rem_q;
    cycles_d = cycles_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opnd_d   = data_in;
          root_d   = '0;
          rem_d    = '0;
          cycles_d = '0;
          state_d  = ITER;
          if ((EARLY_EXIT != 0) && (data_in == '0)) begin
            cycles_d = CW'(1);
            state_d  = DONE;
          end
        end
      end
      ITER: begin
        // Operand shifts left so the next bit-pair is always at the top.
        opnd_d   = opnd_q << 2;
        root_d   = root_nx;
        rem_d    = rem_nx;
        cycles_d = cycles_q + CW'(1);
        if (cycles_q == CW'(RW - 1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy      = (state_q == ITER);
  assign done      = (state_q == DONE);
  assign data_out  = root_q;
  assign remainder = RW1'(rem_q);
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: four instances (N=8, N=8 early-exit, N=12, N=16) against a floor-sqrt model.
module tb_isqrt_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic st8, st8e, st12, st16;
  logic [7:0]  di8, di8e;
  logic [11:0] di12;
  logic [15:0] di16;

  logic b8, b8e, b12, b16;
  logic d8, d8e, d12, d16;
  logic [3:0] q8, q8e;
  logic [5:0] q12;
  logic [7:0] q16;
  logic [4:0] r8, r8e;
  logic [6:0] r12;
  logic [8:0] r16;
  logic [2:0] c8, c8e, c12;
  logic [3:0] c16;

  isqrt_seq #(.N(8), .EARLY_EXIT(0)) dut8 (
    .clock(clock), .reset(reset), .start(st8), .data_in(di8), .busy(b8), .done(d8),
    .data_out(q8), .remainder(r8), .cycles(c8));
  isqrt_seq #(.N(8), .EARLY_EXIT(1)) dut8e (
    .clock(clock), .reset(reset), .start(st8e), .data_in(di8e), .busy(b8e), .done(d8e),
    .data_out(q8e), .remainder(r8e), .cycles(c8e));
  isqrt_seq #(.N(12), .EARLY_EXIT(0)) dut12 (
    .clock(clock), .reset(reset), .start(st12), .data_in(di12), .busy(b12), .done(d12),
    .data_out(q12), .remainder(r12), .cycles(c12));
  isqrt_seq #(.N(16), .EARLY_EXIT(0)) dut16 (
    .clock(clock), .reset(reset), .start(st16), .data_in(di16), .busy(b16), .done(d16),
    .data_out(q16), .remainder(r16), .cycles(c16));

  int o_busy[4], o_done[4], o_dout[4], o_rem[4], o_cyc[4];

  always_comb begin
    o_busy[0] = 32'(b8);  o_done[0] = 32'(d8);  o_dout[0] = 32'(q8);  o_rem[0] = 32'(r8);  o_cyc[0] = 32'(c8);
    o_busy[1] = 32'(b8e); o_done[1] = 32'(d8e); o_dout[1] = 32'(q8e); o_rem[1] = 32'(r8e); o_cyc[1] = 32'(c8e);
    o_busy[2] = 32'(b12); o_done[2] = 32'(d12); o_dout[2] = 32'(q12); o_rem[2] = 32'(r12); o_cyc[2] = 32'(c12);
    o_busy[3] = 32'(b16); o_done[3] = 32'(d16); o_dout[3] = 32'(q16); o_rem[3] = 32'(r16); o_cyc[3] = 32'(c16);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input int v);
    case (sel)
      0: begin st8  = s; di8  = 8'(v);  end
      1: begin st8e = s; di8e = 8'(v);  end
      2: begin st12 = s; di12 = 12'(v); end
      default: begin st16 = s; di16 = 16'(v); end
    endcase
  endtask

  function automatic int isqrt_ref(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Full operation: accept, scramble data_in, wait for done (bounded), compare with model.
  task automatic run_op(input int sel, input int v, input int rw, input bit ee, input string tag);
    int lat, bcnt, r, exp_lat;
    @(negedge clock); drive(sel, 1'b1, v);
    @(negedge clock); drive(sel, 1'b0, int'($urandom));
    lat  = 0;
    bcnt = (o_busy[sel] != 0) ? 1 : 0;
    while (o_done[sel] == 0 && lat < 40) begin
      @(negedge clock);
      lat++;
      if (o_busy[sel] != 0) bcnt++;
    end
    r       = isqrt_ref(v);
    exp_lat = (ee && v == 0) ? 0 : rw;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, bcnt, exp_lat);
    chk({tag, " data_out"}, o_dout[sel], r);
    chk({tag, " remainder"}, o_rem[sel], v - r * r);
    chk({tag, " cycles"}, o_cyc[sel], (exp_lat == 0) ? 1 : rw);
  endtask

  initial begin
    bit [31:0] stride, off, val;
    int done_seen;
    reset = 1'b0;
    st8 = 0; st8e = 0; st12 = 0; st16 = 0;
    di8 = 0; di8e = 0; di12 = 0; di16 = 0;
    repeat (3) @(negedge clock);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("reset busy%0d", s), o_busy[s], 0);
      chk($sformatf("reset done%0d", s), o_done[s], 0);
      chk($sformatf("reset dout%0d", s), o_dout[s], 0);
      chk($sformatf("reset rem%0d", s), o_rem[s], 0);
      chk($sformatf("reset cyc%0d", s), o_cyc[s], 0);
    end
    reset = 1'b1;

    run_op(0, 255, 4, 0, "n8 255");
    chk("n8 255 exact root", o_dout[0], 15);
    chk("n8 255 exact rem", o_rem[0], 30);
    run_op(0, 144, 4, 0, "n8 144");
    run_op(0, 0, 4, 0, "n8 zero");
    run_op(1, 0, 4, 1, "n8e zero");
    run_op(1, 200, 4, 1, "n8e 200");
    run_op(3, 65535, 8, 0, "n16 65535");
    chk("n16 65535 exact rem", o_rem[3], 510);
    run_op(3, 2, 8, 0, "n16 2");

    // Start during ITER is ignored; result held in DONE; restart from DONE.
    @(negedge clock); drive(0, 1'b1, 200);
    @(negedge clock); drive(0, 1'b0, 200);
    @(negedge clock); drive(0, 1'b1, 9);
    @(negedge clock); drive(0, 1'b0, 9);
    chk("ignore busy", o_busy[0], 1);
    @(negedge clock);
    chk("ignore done t0+3", o_done[0], 0);
    @(negedge clock);
    chk("ignore done t0+4", o_done[0], 1);
    chk("ignore dout", o_dout[0], 14);
    chk("ignore rem", o_rem[0], 4);
    chk("ignore cyc", o_cyc[0], 4);
    repeat (3) @(negedge clock);
    chk("hold dout", o_dout[0], 14);
    chk("hold rem", o_rem[0], 4);
    chk("hold done", o_done[0], 1);
    @(negedge clock); drive(0, 1'b1, 9);
    @(negedge clock); drive(0, 1'b0, 0);
    chk("restart done drops", o_done[0], 0);
    for (int k = 0; k < 10 && o_done[0] == 0; k++) @(negedge clock);
    chk("restart dout", o_dout[0], 3);
    chk("restart rem", o_rem[0], 0);

    // Reset in the middle of an iteration.
    @(negedge clock); drive(0, 1'b1, 255);
    @(negedge clock); drive(0, 1'b0, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    chk("abort busy", o_busy[0], 0);
    chk("abort done", o_done[0], 0);
    chk("abort dout", o_dout[0], 0);
    chk("abort rem", o_rem[0], 0);
    chk("abort cyc", o_cyc[0], 0);
    reset = 1'b1;
    done_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (o_done[0] != 0 || o_busy[0] != 0) done_seen = 1;
    end
    chk("abort stays idle", done_seen, 0);

    // Start held during reset is ignored.
    reset = 1'b0; drive(0, 1'b1, 50);
    @(negedge clock);
    chk("start in reset busy", o_busy[0], 0);
    drive(0, 1'b0, 0); reset = 1'b1;
    @(negedge clock);
    chk("after reset busy", o_busy[0], 0);
    chk("after reset done", o_done[0], 0);

    // Exhaustive N=8 and N=12 in a random permutation order.
    stride = $urandom | 32'd1; off = $urandom;
    for (int i = 0; i < 256; i++) begin
      val = (off + 32'(i) * stride) & 32'hFF;
      run_op(0, int'(val), 4, 0, "n8 sweep");
    end
    stride = $urandom | 32'd1; off = $urandom;
    for (int i = 0; i < 4096; i++) begin
      val = (off + 32'(i) * stride) & 32'hFFF;
      run_op(2, int'(val), 6, 0, "n12 sweep");
    end
    for (int i = 0; i < 40; i++) run_op(1, int'($urandom_range(0, 255)), 4, 1, "n8e rand");
    for (int i = 0; i < 150; i++) run_op(3, int'($urandom_range(0, 65535)), 8, 0, "n16 rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/isqrt_seq.md
ISQRT_SEQ -- requirements
Module: isqrt_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, operand width; even, 4..32.
REQ-002 The block SHALL have parameter EARLY_EXIT, default 0; 1 enables the zero-operand shortcut.
REQ-003 The block SHALL define localparam RW = N/2 (root width) and CW = $clog2(N/2+2) (cycle-count width).
REQ-004 The block SHALL have port clock  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  request; accepted only in IDLE or DONE.
REQ-007 The block SHALL have port data_in  input  N  unsigned operand, sampled on the accepting edge.
REQ-008 The block SHALL have port busy  output  1  high while iterating.
REQ-009 The block SHALL have port done  output  1  level; high in DONE until the next accept or reset.
REQ-010 The block SHALL have port data_out  output  RW  floor(sqrt(operand)).
REQ-011 The block SHALL have port remainder  output  RW+1  operand - data_out^2.
REQ-012 The block SHALL have port cycles  output  CW  clock edges spent in ITER for the last operation.

Function
REQ-013 The FSM SHALL have states IDLE, ITER and DONE.
REQ-014 IDLE/DONE with start=1 at edge t0: operand latched, root/rem/step counter cleared, cycles cleared, state to ITER, done=0, busy=1.
REQ-015 In ITER each edge SHALL do one digit-by-digit step (MS bit-pair first): rem=(rem<<2)|pair; trial=(root<<2)|1; if rem>=trial then rem-=trial, root=(root<<1)|1, else root<<=1; cycles+=1.
REQ-016 After RW ITER edges (edge t0+RW), state SHALL move to DONE: done=1, busy=0, data_out/remainder/cycles valid; cycles=RW.
REQ-017 The internal remainder SHALL be RW+2 bits wide, so the trial compare never overflows; the output SHALL be its low RW+1 bits, which always suffice.
REQ-018 start while in ITER SHALL be ignored, with no effect on the operand or the result.
REQ-019 start in DONE SHALL be accepted as in REQ-014; done falls on the same edge.
REQ-020 With EARLY_EXIT=1 and a latched operand of 0, the accepting edge SHALL go directly to DONE with data_out=0, remainder=0, cycles=1; otherwise zero takes the full RW edges.
REQ-021 data_out, remainder and cycles SHALL hold stable from DONE until the next accepting edge or reset.
REQ-022 data_in changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-023 reset=0 at an edge SHALL force IDLE; busy, done, data_out, remainder, cycles and all internal registers SHALL be 0.
REQ-024 Reset mid-ITER SHALL abort the operation, with no partial result visible.
REQ-025 While reset=0, start SHALL be ignored.

Structure
REQ-026 Package isqrt_pkg SHALL hold the state enum (IDLE, ITER, DONE) and a width-helper function returning $clog2(n/2+2).
REQ-027 One combinational sub-module, isqrt_step (parameter RW), SHALL implement a single iteration of REQ-015 (inputs: rem, root, pair; outputs: next rem, next root).
REQ-028 The FSM and step counter SHALL live in isqrt_seq; no other sub-modules.

Verification
REQ-029 N=8: start with data_in=255 -> done at t0+4, data_out=15, remainder=30, cycles=4, busy high for 4 cycles.
REQ-030 N=8: data_in=144 -> data_out=12, remainder=0; then data_in=0 -> EARLY_EXIT=0: 0/0/cycles=4; EARLY_EXIT=1: 0/0/cycles=1 with done at t0.
REQ-031 N=16: data_in=65535 -> data_out=255, remainder=510, cycles=8; data_in=2 -> data_out=1, remainder=1.
REQ-032 N=8: start at t0 with 200, start=1 with data_in=9 at t0+2 -> ignored; result is 14/4; a start in DONE with 9 -> done drops, then 3/0.
REQ-033 N=8: reset=0 at t0+2 during ITER -> next cycle IDLE, all outputs 0, and done does not rise without a new start.
REQ-034 The bench SHALL run exhaustive random checks for N=8 and N=12 against a floor-sqrt model, comparing data_out, remainder and cycles.
